adc128s022_ctrl: RTL
====================

ADC128S022_CTRL -- requirements
Module: adc128s022_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 13, SHALL set the SCLK half-period in clk cycles (50 MHz clk -> ~1.92 MHz SCLK); legal range 2..255.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 conv_go  input  1  single-cycle request to start one conversion frame.
REQ-005 channel  input  3  ADC channel address to send in the requested frame.
REQ-006 adc_cs_n  output  1  ADC chip select, active-low.
REQ-007 adc_sclk  output  1  ADC serial clock; idles high.
REQ-008 adc_din  output  1  command bit to the ADC.
REQ-009 adc_dout  input  1  data bit from the ADC.
REQ-010 adc_data  output  12  last converted sample; feeds the sample FIFO/UART packer.
REQ-011 adc_data_valid_go  output  1  one-cycle strobe qualifying a new adc_data.
REQ-012 adc_data_ch  output  3  channel that adc_data belongs to.
REQ-013 adc_busy  output  1  high while a frame is in progress.

Function
REQ-014 FSM SHALL be one-hot with states IDLE, START, XFER, STOP.
REQ-015 IDLE: on conv_go=1, the FSM SHALL latch channel into cmd_ch, move to START, and drive adc_cs_n=0 and adc_busy=1 from the next cycle.
REQ-016 conv_go SHALL be ignored in any state other than IDLE, with no queuing.
REQ-017 START SHALL last CLK_DIV cycles with adc_sclk=1 and adc_din=0, then move to XFER.
REQ-018 XFER SHALL run a half-period counter 0..CLK_DIV-1; each wrap SHALL toggle adc_sclk and increment edge_cnt over 0..31.
REQ-019 Even edge_cnt SHALL be a falling edge; at falling edge k (k=0..15), adc_din SHALL become cmd[15-k].
REQ-020 cmd SHALL be {2'b00, cmd_ch, 11'b0}, MSB first, so the ADC sees ADD2..0 on SCLK rising edges 3..5.
REQ-021 Odd edge_cnt SHALL be a rising edge; on it, adc_dout SHALL shift into a 16-bit register, MSB first.
REQ-022 After edge 31 (the 16th rising edge), the FSM SHALL enter STOP with adc_sclk=1.
REQ-023 In that same cycle, adc_data SHALL load shift[11:0] and adc_data_valid_go SHALL pulse for exactly 1 cycle.
REQ-024 STOP SHALL hold adc_cs_n=0 for CLK_DIV cycles, then drive adc_cs_n=1, adc_busy=0, and return to IDLE.
REQ-025 Frame length SHALL be conv_go cycle + 34*CLK_DIV cycles with adc_busy=1.
REQ-026 The ADC returns the channel addressed in the previous frame, so adc_data_ch SHALL equal the cmd_ch of the preceding frame.
REQ-027 After reset, the previous-channel register SHALL be 0.
REQ-028 A conv_go arriving in the cycle the FSM returns to IDLE SHALL be accepted, because the FSM is already in IDLE; back-to-back frames SHALL then have at least 1 IDLE cycle with adc_cs_n=1 between them.
REQ-029 The upper 4 bits of the shift register (ADC leading zeros) SHALL be discarded without checking.

Reset
REQ-030 While rst_n=0, the block SHALL drive adc_cs_n=1, adc_sclk=1, adc_din=0, adc_data=0, adc_data_ch=0, adc_data_valid_go=0, adc_busy=0, with the FSM in IDLE and all counters at 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately with no adc_data_valid_go.
REQ-032 After rst_n deasserts, the block SHALL wait in IDLE for a new conv_go.

Verification (CLK_DIV=2 unless stated)
REQ-033 Reset mid-XFER -> all outputs SHALL return to REQ-030 values asynchronously, and no strobe SHALL appear.
REQ-034 conv_go with channel=5 and an ADC model returning 0xA5C -> the bench SHALL check:
- adc_din = 1,0,1 on rising edges 3..5;
- exactly 16 SCLK rising edges;
- adc_data=12'hA5C with a 1-cycle strobe;
- adc_busy high for 68 cycles.
REQ-035 Two frames, channel 3 then channel 6 -> the second frame SHALL report adc_data_ch=3, and the first SHALL report adc_data_ch=0.
REQ-036 conv_go pulses at cycles 10 and 30 of a busy frame -> both SHALL be ignored, giving exactly one frame and one strobe.
REQ-037 conv_go held high continuously -> frames SHALL repeat, with adc_cs_n=1 for exactly 1 cycle between frames.
REQ-038 CLK_DIV=13 -> the SCLK period SHALL be 26 clk cycles at 50% duty, and a frame SHALL last 442 busy cycles.

Source files
------------

// File: rtl/adc128s022_ctrl_if.sv
// Bus between the ADC128S022 controller and its environment: host request/result
// signals plus the four ADC serial pins.
interface adc128s022_ctrl_if;
  logic        conv_go;
  logic [2:0]  channel;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_din;
  logic        adc_dout;
  logic [11:0] adc_data;
  logic        adc_data_valid_go;
  logic [2:0]  adc_data_ch;
  logic        adc_busy;

  // master is the surrounding system: the host issuing requests and the ADC answering
  modport master (
    output conv_go, channel, adc_dout,
    input  adc_cs_n, adc_sclk, adc_din, adc_data, adc_data_valid_go, adc_data_ch, adc_busy
  );

  modport slave (
    input  conv_go, channel, adc_dout,
    output adc_cs_n, adc_sclk, adc_din, adc_data, adc_data_valid_go, adc_data_ch, adc_busy
  );
endinterface

// File: rtl/adc128s022_ctrl.sv
// ADC128S022 frame controller: one 16-SCLK SPI frame per conv_go, sending the
// channel address and returning the 12-bit sample of the previously addressed channel.
//
// state | meaning
// IDLE  | CS high, waiting for conv_go
// START | CS low, SCLK high for CLK_DIV cycles before the first falling edge
// XFER  | 32 SCLK half-periods; command out on falls, data in on rises
// STOP  | SCLK high, CS held low for CLK_DIV cycles, then release
module adc128s022_ctrl #(
  parameter int CLK_DIV = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  adc128s022_ctrl_if.slave bus
);

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_START = 4'b0010;
  localparam logic [3:0] S_XFER  = 4'b0100;
  localparam logic [3:0] S_STOP  = 4'b1000;

  localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

  logic [3:0]  r_state;
  logic [7:0]  r_cnt;
  logic [4:0]  r_edge;
  logic [2:0]  r_cmd_ch;
  logic [2:0]  r_prev_ch;
  logic [10:0] r_shift;
  logic        r_cs_n;
  logic        r_sclk;
  logic        r_din;
  logic        r_busy;
  logic        r_valid;
  logic [11:0] r_data;
  logic [2:0]  r_data_ch;

  logic        w_wrap;
  logic [15:0] w_cmd;
  logic [11:0] w_sample;

  assign w_wrap   = (r_cnt == CNT_MAX);
  assign w_cmd    = {2'b00, r_cmd_ch, 11'b0};
  // Older bits (the ADC's four leading zeros) fall off the top of the shifter unchecked.
  assign w_sample = {r_shift, bus.adc_dout};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_edge    <= '0;
      r_cmd_ch  <= '0;
      r_prev_ch <= '0;
      r_shift   <= '0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b1;
      r_din     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_data_ch <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.conv_go) begin
            r_state  <= S_START;
            r_cnt    <= '0;
            r_cmd_ch <= bus.channel;
            r_cs_n   <= 1'b0;
            r_busy   <= 1'b1;
            r_sclk   <= 1'b1;
            r_din    <= 1'b0;
          end
        end
        S_START: begin
          if (w_wrap) begin
            r_state <= S_XFER;
            r_cnt   <= '0;
            r_edge  <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_XFER: begin
          if (w_wrap) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 5'd1;
            if (!r_edge[0]) begin
              r_din <= w_cmd[4'd15 - r_edge[4:1]];
            end else begin
              r_shift <= w_sample[10:0];
              if (r_edge == 5'd31) begin
                r_state   <= S_STOP;
                r_data    <= w_sample;
                r_valid   <= 1'b1;
                // The ADC converts the channel addressed one frame earlier.
                r_data_ch <= r_prev_ch;
                r_prev_ch <= r_cmd_ch;
              end
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_STOP: begin
          if (w_wrap) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_sclk  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.adc_cs_n          = r_cs_n;
  assign bus.adc_sclk          = r_sclk;
  assign bus.adc_din           = r_din;
  assign bus.adc_busy          = r_busy;
  assign bus.adc_data          = r_data;
  assign bus.adc_data_valid_go = r_valid;
  assign bus.adc_data_ch       = r_data_ch;

endmodule
